// File: rtl/mem_map_pkg.sv
// Shared address map, error-bit layout and region decode for the data-side memory responder.
package mem_map_pkg;

  localparam int unsigned ADDR_W = 21;
  localparam int unsigned DATA_W = 32;

  localparam logic [3:0] OFF_TX_DATA   = 4'h0;
  localparam logic [3:0] OFF_TX_STATUS = 4'h4;
  localparam logic [3:0] OFF_CYCLE     = 4'h8;
  localparam logic [3:0] OFF_ERR       = 4'hC;

  localparam int unsigned ERR_MISALIGNED = 0;
  localparam int unsigned ERR_UNMAPPED   = 1;
  localparam int unsigned ERR_OVF        = 2;
  localparam int unsigned ERR_W          = 3;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_e;

  // base_hi is the 16-byte-aligned MMIO base without its low nibble.
  function automatic region_e decode_region(input logic [ADDR_W-1:0] a,
                                            input logic [16:0]        base_hi,
                                            input logic [19:0]        depth);
    if ({1'b0, a[20:2]} < depth) return REG_RAM;
    if (a[20:4] == base_hi)      return REG_MMIO;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU M-stage bus, host preload port and TX stream port of the data memory responder.
interface data_mem_responder_if;
  import mem_map_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dataWrite;
  logic              memWrite;
  logic [DATA_W-1:0] dataRead;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              err_irq;

  modport slave (
    input  addr, dataWrite, memWrite, host_we, host_addr, host_wdata, tx_ready,
    output dataRead, tx_valid, tx_data, err_irq
  );

  modport master (
    output addr, dataWrite, memWrite, host_we, host_addr, host_wdata, tx_ready,
    input  dataRead, tx_valid, tx_data, err_irq
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted only when a pop frees a slot that cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; reset only empties the FIFO through the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/data_mem_responder.sv
// Data-side memory responder: word RAM plus MMIO window (TX FIFO, cycle counter, sticky errors).
module data_mem_responder
  import mem_map_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = 1024,
  parameter int unsigned       FIFO_DEPTH  = 8,
  parameter logic [ADDR_W-1:0] MMIO_BASE   = 21'h1F0000
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);
  localparam int unsigned RAM_AW  = $clog2(DEPTH_WORDS);
  localparam int unsigned FIFO_CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0]  ram [DEPTH_WORDS];
  logic [31:0]        cycle;
  logic [ERR_W-1:0]   err;
  logic [ERR_W-1:0]   err_set;
  logic [ERR_W-1:0]   err_clr;
  region_e            cpu_region;
  region_e            host_region;
  logic               misaligned;
  logic               ram_we;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FIFO_CW-1:0] fifo_count;
  logic [DATA_W-1:0]  fifo_dout;
  logic [DATA_W-1:0]  rdata;
  logic [RAM_AW-1:0]  cpu_idx;
  logic [RAM_AW-1:0]  host_idx;
  logic               unused_host_lsb;

  assign cpu_region      = decode_region(bus.addr, MMIO_BASE[20:4], 20'(DEPTH_WORDS));
  assign host_region     = decode_region(bus.host_addr, MMIO_BASE[20:4], 20'(DEPTH_WORDS));
  assign misaligned      = (bus.addr[1:0] != 2'b00);
  assign cpu_idx         = bus.addr[RAM_AW+1:2];
  assign host_idx        = bus.host_addr[RAM_AW+1:2];
  assign unused_host_lsb = ^bus.host_addr[1:0];

  // CPU store decode: RAM write, FIFO push, error set/clear.
  always_comb begin
    ram_we  = 1'b0;
    push    = 1'b0;
    err_set = '0;
    err_clr = '0;
    if (bus.memWrite) begin
      if (misaligned) begin
        err_set[ERR_MISALIGNED] = 1'b1;
      end else begin
        case (cpu_region)
          REG_RAM:  ram_we = 1'b1;
          REG_MMIO: begin
            if (bus.addr[3:0] == OFF_TX_DATA) push    = 1'b1;
            if (bus.addr[3:0] == OFF_ERR)     err_clr = bus.dataWrite[ERR_W-1:0];
          end
          default:  err_set[ERR_UNMAPPED] = 1'b1;
        endcase
      end
    end
    if (push && fifo_full && !pop) err_set[ERR_OVF] = 1'b1;
  end

  // Host write first so a same-word CPU store overrides it.
  always_ff @(posedge clk) begin
    if (bus.host_we && host_region == REG_RAM) ram[host_idx] <= bus.host_wdata;
    if (ram_we)                                ram[cpu_idx]  <= bus.dataWrite;
  end

  // Free-running counter and sticky error flags; set beats clear on the same bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle <= '0;
      err   <= '0;
    end else begin
      cycle <= cycle + 32'd1;
      err   <= (err & ~err_clr) | err_set;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.dataWrite),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pop = bus.tx_valid && bus.tx_ready;

  // Combinational load path; unmapped or misaligned reads return zero.
  always_comb begin
    rdata = '0;
    if (!misaligned) begin
      case (cpu_region)
        REG_RAM:  rdata = ram[cpu_idx];
        REG_MMIO: begin
          case (bus.addr[3:0])
            OFF_TX_STATUS: rdata = {16'(fifo_count), 14'b0, fifo_full, fifo_empty};
            OFF_CYCLE:     rdata = cycle;
            OFF_ERR:       rdata = 32'(err);
            default:       rdata = '0;
          endcase
        end
        default:  rdata = '0;
      endcase
    end
  end

  assign bus.dataRead = rdata;
  assign bus.tx_valid = !fifo_empty;
  assign bus.tx_data  = fifo_dout;
  assign bus.err_irq  = |err;
endmodule
